// File: rtl/quadrature_step_decoder.sv
// Quadrature encoder step decoder: 2-flop synchronizers, per-channel glitch filters and a PRIME/TRACK decoder FSM.
// Optional macro QDEC_ERR_COUNT_EN adds a saturating illegal-transition counter output err_count.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_PRIME | waiting for both filtered channels to settle, then capture prev
// S_TRACK | decoding changes of filtered {A,B} into steps / errors
module quadrature_step_decoder #(
    parameter int               WIDTH       = 4,
    parameter int               FILTER_LEN  = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(5)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             quad_a,
    input  logic             quad_b,
    input  logic             enable,
    input  logic             set,
    input  logic [WIDTH-1:0] set_value,
    output logic             step,
    output logic             up_down,
    output logic [WIDTH-1:0] count,
    output logic             err,
    output logic             max_flag,
    output logic             min_flag
`ifdef QDEC_ERR_COUNT_EN
    ,
    output logic [3:0]       err_count
`endif
);

    typedef enum logic {S_PRIME, S_TRACK} state_t;

    localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
    localparam logic [3:0] FL_FULL = 4'(FILTER_LEN);

    // bit 1 carries channel A, bit 0 channel B, so vectors read as {A,B}
    logic [1:0] r_sync1;
    logic [1:0] r_sync2;
    logic [1:0] r_level;
    logic [3:0] r_fcnt [2];
    logic [3:0] r_stab [2];

    state_t           r_state;
    logic [1:0]       r_prev;
    logic             r_step;
    logic             r_up_down;
    logic [WIDTH-1:0] r_count;
    logic             r_err;

    state_t           w_state_nxt;
    logic [1:0]       w_prev_nxt;
    logic             w_step_nxt;
    logic             w_up_down_nxt;
    logic [WIDTH-1:0] w_count_nxt;
    logic             w_err_nxt;
    logic             w_stable;
    logic [1:0]       w_up_next;
    logic [1:0]       w_down_next;

`ifdef QDEC_ERR_COUNT_EN
    logic [3:0] r_err_cnt;
    logic [3:0] w_err_cnt_nxt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
            r_level <= 2'b00;
            for (int ch = 0; ch < 2; ch++) begin
                r_fcnt[ch] <= 4'd0;
                r_stab[ch] <= 4'd0;
            end
        end else begin
            r_sync1 <= {quad_a, quad_b};
            r_sync2 <= r_sync1;
            for (int ch = 0; ch < 2; ch++) begin
                if (r_sync2[ch] == r_level[ch]) begin
                    r_fcnt[ch] <= 4'd0;
                    if (r_stab[ch] != FL_FULL) begin
                        r_stab[ch] <= r_stab[ch] + 4'd1;
                    end
                end else begin
                    r_stab[ch] <= 4'd0;
                    if (r_fcnt[ch] == FL_LAST) begin
                        r_level[ch] <= r_sync2[ch];
                        r_fcnt[ch]  <= 4'd0;
                    end else begin
                        r_fcnt[ch]  <= r_fcnt[ch] + 4'd1;
                    end
                end
            end
        end
    end

    assign w_stable    = (r_stab[0] == FL_FULL) && (r_stab[1] == FL_FULL);
    // Gray successor / predecessor of the previous level in the up direction
    assign w_up_next   = {r_prev[0], ~r_prev[1]};
    assign w_down_next = {~r_prev[0], r_prev[1]};

    always_comb begin
        w_state_nxt   = r_state;
        w_prev_nxt    = r_prev;
        w_step_nxt    = 1'b0;
        w_up_down_nxt = r_up_down;
        w_count_nxt   = r_count;
        w_err_nxt     = r_err;
`ifdef QDEC_ERR_COUNT_EN
        w_err_cnt_nxt = r_err_cnt;
`endif
        case (r_state)
            S_PRIME: begin
                if (w_stable) begin
                    w_prev_nxt  = r_level;
                    w_state_nxt = S_TRACK;
                end
            end
            S_TRACK: begin
                if (r_level != r_prev) begin
                    w_prev_nxt = r_level;
                    if (enable) begin
                        if (r_level == w_up_next) begin
                            w_step_nxt    = 1'b1;
                            w_up_down_nxt = 1'b1;
                            w_count_nxt   = r_count + 1'b1;
                        end else if (r_level == w_down_next) begin
                            w_step_nxt    = 1'b1;
                            w_up_down_nxt = 1'b0;
                            w_count_nxt   = r_count - 1'b1;
                        end else begin
                            w_err_nxt = 1'b1;
`ifdef QDEC_ERR_COUNT_EN
                            if (r_err_cnt != 4'hF) begin
                                w_err_cnt_nxt = r_err_cnt + 4'd1;
                            end
`endif
                        end
                    end
                end
            end
            default: w_state_nxt = S_PRIME;
        endcase
        // an explicit load wins over a coincident step but leaves step/up_down intact
        if (set) begin
            w_count_nxt = set_value;
            w_err_nxt   = 1'b0;
`ifdef QDEC_ERR_COUNT_EN
            w_err_cnt_nxt = 4'd0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_PRIME;
            r_prev    <= 2'b00;
            r_step    <= 1'b0;
            r_up_down <= 1'b0;
            r_count   <= RESET_VALUE;
            r_err     <= 1'b0;
`ifdef QDEC_ERR_COUNT_EN
            r_err_cnt <= 4'd0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_prev    <= w_prev_nxt;
            r_step    <= w_step_nxt;
            r_up_down <= w_up_down_nxt;
            r_count   <= w_count_nxt;
            r_err     <= w_err_nxt;
`ifdef QDEC_ERR_COUNT_EN
            r_err_cnt <= w_err_cnt_nxt;
`endif
        end
    end

    assign step     = r_step;
    assign up_down  = r_up_down;
    assign count    = r_count;
    assign err      = r_err;
    assign max_flag = &r_count;
    assign min_flag = ~|r_count;
`ifdef QDEC_ERR_COUNT_EN
    assign err_count = r_err_cnt;
`endif

endmodule
